// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial ADD/SUB/INC/MUL coprocessor built around one full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] OP_SUB = 2'b01, OP_MUL = 2'b10, OP_INC = 2'b11;
  typedef enum logic [1:0] {IDLE, SER, MTEST, MADD} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] x, y, s, p, m, q, sum_vec;
  logic [CW-1:0] cnt, mcnt;
  logic cf, sum, co, last, mlast;
  full_adder u_fa (.a(x[0]), .b(y[0]), .ci(cf), .s(sum), .co(co));
  assign sum_vec = WIDTH'({sum, s} >> 1);
  assign last = cnt == LAST;
  assign mlast = mcnt == LAST;
  assign ready = state == IDLE;
  assign busy = ~ready;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = start ? (op == OP_MUL ? MTEST : SER) : IDLE;
      SER:   nxt = last ? IDLE : SER;
      MTEST: nxt = q[0] ? MADD : (mlast ? IDLE : MTEST);
      MADD:  nxt = last ? (mlast ? IDLE : MTEST) : MADD;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      {x, y, s, p, m, q} <= '0;
      {cnt, mcnt, cf} <= '0;
      {result, carry, zero, done} <= '0;
    end else begin
      state <= nxt;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          x <= a;
          y <= op == OP_SUB ? ~b : (op == OP_INC ? '0 : b);
          cf <= op == OP_SUB || op == OP_INC;
          cnt <= '0;
          p <= '0;
          m <= a;
          q <= b;
          mcnt <= '0;
        end
        SER, MADD: begin
          x <= x >> 1;
          y <= y >> 1;
          s <= sum_vec;
          cf <= co;
          cnt <= cnt + 1'b1;
          if (last && state == SER) begin
            result <= sum_vec;
            carry <= co;
            zero <= sum_vec == '0;
            done <= 1'b1;
          end
          if (last && state == MADD) begin
            p <= sum_vec;
            m <= m << 1;
            q <= q >> 1;
            mcnt <= mcnt + 1'b1;
            if (mlast) begin
              result <= sum_vec;
              carry <= 1'b0;
              zero <= sum_vec == '0;
              done <= 1'b1;
            end
          end
        end
        MTEST: if (q[0]) begin
          x <= p;
          y <= m;
          cf <= 1'b0;
          cnt <= '0;
        end else begin
          m <= m << 1;
          q <= q >> 1;
          mcnt <= mcnt + 1'b1;
          if (mlast) begin
            result <= p;
            carry <= 1'b0;
            zero <= p == '0;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
